shift_seq_ctrl: RTL

Sequencer that drives a parallel-load, bidirectional shift register of WIDTH bits as a serial transfer engine. It accepts a parallel word over a ready/start handshake, loads it into the shift register, and issues exactly WIDTH shift pulses at a programmable bit rate. It then captures the word shifted in from the serial input. It sits between the bus-side requester and the shift-register datapath and owns every control pin of that datapath except its reset.

---
 rtl/shift_seq_pkg.sv | 16 +
 rtl/shift_seq_ctrl_if.sv | 22 ++
 rtl/shift_tick.sv | 31 +++
 rtl/shift_seq_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types for the serial shift sequencer: FSM states and
// shift-direction encodings.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        SHIFT,
        DONE
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Requester-side handshake bundle of the shift sequencer.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] tx_word;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_word;

    modport master (
        output start, dir, tx_word,
        input  ready, busy, done, rx_word
    );

    modport slave (
        input  start, dir, tx_word,
        output ready, busy, done, rx_word
    );
endinterface

// File: rtl/shift_tick.sv
// Bit-period divider: counts 0..DIV-2 while enabled, ticks on the last
// count. With DIV=1 every cycle is a bit period, so tick is tied high.
module shift_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LASTI = (DIV > 1) ? DIV - 2 : 0;
    localparam logic [CW-1:0] LAST = CW'(LASTI);

    logic [CW-1:0] cnt;
    logic          hit;

    assign hit  = en && (cnt == LAST);
    assign tick = (DIV == 1) ? 1'b1 : hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || hit) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial transfer sequencer: loads a word into an external shift
// register, issues WIDTH shift strobes at DIV clocks per bit, captures.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    shift_seq_ctrl_if.slave  bus,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             sr_ld,
    output logic             sr_sr,
    output logic             sr_sl,
    output logic             sr_inl,
    output logic             sr_inr,
    output logic [WIDTH-1:0] sr_d,
    input  logic [WIDTH-1:0] sr_q
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LASTB = BW'(WIDTH - 1);

    state_t           state;
    state_t           nxt;
    logic [BW-1:0]    bcnt;
    logic             dir_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] rx_q;
    logic             tick;
    logic             tick_clr;
    logic             tick_en;
    logic             accept;

    shift_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    assign accept      = (state == IDLE) && bus.start;
    assign bus.ready   = (state == IDLE);
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.rx_word = rx_q;
    assign sr_d        = word_q;
    assign sr_inl      = ser_in;
    assign sr_inr      = ser_in;
    assign ser_out     = (dir_q == DIR_LEFT) ? sr_q[WIDTH-1] : sr_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bcnt   <= '0;
            dir_q  <= DIR_RIGHT;
            word_q <= '0;
            rx_q   <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                word_q <= bus.tx_word;
                dir_q  <= bus.dir;
                bcnt   <= '0;
            end
            if (state == SHIFT) begin
                bcnt <= bcnt + BW'(1);
            end
            // sr_q already holds the final shift by the DONE cycle
            if (state == DONE) begin
                rx_q <= sr_q;
            end
        end
    end

    always_comb begin
        nxt      = state;
        sr_ld    = 1'b0;
        sr_sr    = 1'b0;
        sr_sl    = 1'b0;
        tick_clr = 1'b1;
        tick_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) nxt = LOAD;
            end
            LOAD: begin
                sr_ld = 1'b1;
                nxt   = (DIV > 1) ? WAIT : SHIFT;
            end
            WAIT: begin
                tick_clr = 1'b0;
                tick_en  = 1'b1;
                if (tick) nxt = SHIFT;
            end
            SHIFT: begin
                sr_sr = (dir_q == DIR_RIGHT);
                sr_sl = (dir_q == DIR_LEFT);
                if (bcnt == LASTB) begin
                    nxt = DONE;
                end else begin
                    nxt = (DIV > 1) ? WAIT : SHIFT;
                end
            end
            DONE: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end
endmodule
